// File: rtl/my_nor.sv
// my_nor: combinational NOR with a registered copy, edge pulses and saturating
// high-time and toggle counters with a sticky saturation flag.
module my_nor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1,
  input  logic             in2,
  output logic             out,
  output logic             out_q,
  output logic             out_rise,
  output logic             out_fall,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             sat_q, sat_d;
  assign out = ~(in1 | in2);
  always_comb begin
    prev_d = out;
    rise_d = out & ~prev_q;
    fall_d = ~out & prev_q;
    high_d = (out && high_q != CNT_MAX) ? high_q + 1'b1 : high_q;
    tog_d  = ((out != prev_q) && tog_q != CNT_MAX) ? tog_q + 1'b1 : tog_q;
    sat_d  = sat_q | (high_d == CNT_MAX) | (tog_d == CNT_MAX);
  end
  // Reset leaves prev at the NOR of 00 so a first sampled 1 makes no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      high_q <= '0;
      tog_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      high_q <= high_d;
      tog_q  <= tog_d;
      sat_q  <= sat_d;
    end
  end
  assign out_q      = prev_q;
  assign out_rise   = rise_q;
  assign out_fall   = fall_q;
  assign high_cnt   = high_q;
  assign toggle_cnt = tog_q;
  assign cnt_sat    = sat_q;
endmodule

// File: tb/tb_my_nor.sv
// tb_my_nor: directed vectors push hand-computed expectations into a queue;
// a monitor pops and compares them against two instances (CNT_W=16 and 2).
module tb_my_nor;
  logic clk, clk_en, rst, in1, in2;
  logic out, out_q, out_rise, out_fall, cnt_sat;
  logic [15:0] high_cnt, toggle_cnt;
  logic out2, out_q2, out_rise2, out_fall2, cnt_sat2;
  logic [1:0] high_cnt2, toggle_cnt2;
  int tests = 0, fails = 0;
  bit started = 0;

  my_nor dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(out), .out_q(out_q),
    .out_rise(out_rise), .out_fall(out_fall), .high_cnt(high_cnt),
    .toggle_cnt(toggle_cnt), .cnt_sat(cnt_sat)
  );

  my_nor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(out2), .out_q(out_q2),
    .out_rise(out_rise2), .out_fall(out_fall2), .high_cnt(high_cnt2),
    .toggle_cnt(toggle_cnt2), .cnt_sat(cnt_sat2)
  );

  typedef struct {
    string nm;
    bit full;
    bit d2;
    logic o, oq, r, f, s;
    logic [31:0] h, t;
  } exp_t;

  exp_t q[$];
  event chk;

  initial begin
    clk = 0;
    clk_en = 0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.d2) begin
          cmp({e.nm, ".out"}, 32'(out2), 32'(e.o));
          if (e.full) begin
            cmp({e.nm, ".out_q"}, 32'(out_q2), 32'(e.oq));
            cmp({e.nm, ".rise"}, 32'(out_rise2), 32'(e.r));
            cmp({e.nm, ".fall"}, 32'(out_fall2), 32'(e.f));
            cmp({e.nm, ".high"}, 32'(high_cnt2), e.h);
            cmp({e.nm, ".tog"}, 32'(toggle_cnt2), e.t);
            cmp({e.nm, ".sat"}, 32'(cnt_sat2), 32'(e.s));
          end
        end else begin
          cmp({e.nm, ".out"}, 32'(out), 32'(e.o));
          if (e.full) begin
            cmp({e.nm, ".out_q"}, 32'(out_q), 32'(e.oq));
            cmp({e.nm, ".rise"}, 32'(out_rise), 32'(e.r));
            cmp({e.nm, ".fall"}, 32'(out_fall), 32'(e.f));
            cmp({e.nm, ".high"}, 32'(high_cnt), e.h);
            cmp({e.nm, ".tog"}, 32'(toggle_cnt), e.t);
            cmp({e.nm, ".sat"}, 32'(cnt_sat), 32'(e.s));
          end
        end
      end
    end
  end

  always @(negedge clk)
    if (started) begin
      cmp("excl_pulse", 32'(out_rise & out_fall), 32'd0);
      cmp("excl_pulse2", 32'(out_rise2 & out_fall2), 32'd0);
    end

  task automatic ex(input string nm, input bit full, input bit d2, input logic o,
                    input logic oq, input logic r, input logic f,
                    input int h, input int t, input logic s);
    exp_t e;
    e.nm = nm; e.full = full; e.d2 = d2;
    e.o = o; e.oq = oq; e.r = r; e.f = f; e.s = s;
    e.h = 32'(h); e.t = 32'(t);
    q.push_back(e);
    ->chk;
    #1;
  endtask

  task automatic step(input logic a, input logic b, input logic r);
    in1 = a;
    in2 = b;
    rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    in1 = 0; in2 = 0; #10; ex("nor00", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    in1 = 0; in2 = 1; #10; ex("nor01", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in1 = 1; in2 = 0; #10; ex("nor10", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in1 = 1; in2 = 1; #10; ex("nor11", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in1 = 1'bx; in2 = 1; #10; ex("norx1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clk_en = 1;
    @(negedge clk);
    step(0, 0, 1);
    started = 1;
    ex("rst", 1, 0, 1, 1, 0, 0, 0, 0, 0);
    ex("rst_w2", 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    ex("hold1", 1, 0, 1, 1, 0, 0, 1, 0, 0);
    ex("sat1", 1, 1, 1, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0);
    ex("hold2", 1, 0, 1, 1, 0, 0, 2, 0, 0);
    ex("sat2", 1, 1, 1, 1, 0, 0, 2, 0, 0);
    step(0, 0, 0);
    ex("hold3", 1, 0, 1, 1, 0, 0, 3, 0, 0);
    ex("sat3", 1, 1, 1, 1, 0, 0, 3, 0, 1);
    step(0, 0, 0);
    ex("hold4", 1, 0, 1, 1, 0, 0, 4, 0, 0);
    ex("sat4", 1, 1, 1, 1, 0, 0, 3, 0, 1);
    step(0, 0, 0);
    ex("hold5", 1, 0, 1, 1, 0, 0, 5, 0, 0);
    ex("sat5", 1, 1, 1, 1, 0, 0, 3, 0, 1);
    step(0, 0, 1);
    ex("rst_b", 1, 0, 1, 1, 0, 0, 0, 0, 0);
    ex("rst_b2", 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    ex("e00", 1, 0, 1, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0);
    ex("e11_fall", 1, 0, 0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0);
    ex("e00_rise", 1, 0, 1, 1, 1, 0, 2, 2, 0);
    step(0, 0, 0);
    ex("e00_quiet", 1, 0, 1, 1, 0, 0, 3, 2, 0);
    ex("e00_quiet2", 1, 1, 1, 1, 0, 0, 3, 2, 1);
    step(1, 0, 1);
    ex("midrst", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    ex("midrst2", 1, 1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    ex("post_rst", 1, 0, 1, 1, 0, 0, 1, 0, 0);
    in1 = 1;
    ex("pulse_out", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex("pulse_regs", 1, 0, 0, 1, 0, 0, 1, 0, 0);
    in1 = 0;
    ex("pulse_back", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    ex("after_pulse", 1, 0, 1, 1, 0, 0, 2, 0, 0);
    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/my_nor.md
MY_NOR -- requirements
Module: my_nor

Interface
REQ-001 The module SHALL have one parameter: CNT_W, default 16, the width of both event counters (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The module SHALL have port in1, input, 1 bit, first NOR operand.
REQ-005 The module SHALL have port in2, input, 1 bit, second NOR operand.
REQ-006 The module SHALL have port out, output, 1 bit, combinational NOR of in1 and in2.
REQ-007 The module SHALL have port out_q, output, 1 bit, registered copy of out.
REQ-008 The module SHALL have port out_rise, output, 1 bit, one-cycle pulse on a registered 0->1 transition.
REQ-009 The module SHALL have port out_fall, output, 1 bit, one-cycle pulse on a registered 1->0 transition.
REQ-010 The module SHALL have port high_cnt, output, CNT_W bits, count of sampled cycles with out=1.
REQ-011 The module SHALL have port toggle_cnt, output, CNT_W bits, count of out_q transitions.
REQ-012 The module SHALL have port cnt_sat, output, 1 bit, sticky flag set when either counter saturates.

Function
REQ-013 out SHALL equal ~(in1 | in2) at all times, purely combinational, with no dependence on clk or rst (truth table 00->1, 01->0, 10->0, 11->0).
REQ-014 out SHALL be correct within the same simulation delta as an input change, even when clk is held constant or floating.
REQ-015 An X or Z on either input SHALL give out=0 when the other input is 1, and X otherwise (standard Verilog NOR semantics).
REQ-016 On each rising clk edge with rst=0, out_q SHALL load the current value of out (latency 1 cycle).
REQ-017 out_rise SHALL be registered and equal 1 for exactly the cycle after out_q changes from 0 to 1; otherwise it SHALL be 0.
REQ-018 out_fall SHALL follow the same rule as out_rise for a change from 1 to 0.
REQ-019 out_rise and out_fall SHALL never be 1 in the same cycle.
REQ-020 Each cycle with rst=0 and out=1 sampled, high_cnt SHALL increment by 1.
REQ-021 high_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022 Each cycle in which out_q changes value, toggle_cnt SHALL increment by 1.
REQ-023 toggle_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 cnt_sat SHALL go to 1 on the edge at which either counter reaches all-ones, and SHALL stay 1 until reset.
REQ-025 Input changes between clock edges SHALL affect only out; registered outputs SHALL see only the value present at the edge.

Reset
REQ-026 While rst=1 at a rising edge, the following SHALL take the listed values on that edge: out_q=1 (the NOR of 00), out_rise=0, out_fall=0, high_cnt=0, toggle_cnt=0, cnt_sat=0.
REQ-027 The first cycle after reset SHALL use out_q=1 as the previous value, so no edge pulse is generated when the first sampled out equals 1.
REQ-028 Reset SHALL NOT affect the combinational out, and reset asserted mid-count SHALL override every increment in that cycle.

Verification
REQ-029 A bench SHALL drive in1,in2 = 00, 01, 10, 11, each held 10 ns with no clock, and require out = 1, 0, 0, 0.
REQ-030 A bench SHALL reset, then hold 00 for 3 clocks, and require high_cnt=3, toggle_cnt=0, out_q=1, and no edge pulses.
REQ-031 A bench SHALL reset, hold 00, then drive 11 for one cycle and then 00, and require out_fall=1 then out_rise=1 on consecutive cycles and toggle_cnt=2.
REQ-032 A bench SHALL use CNT_W=2 and hold 00 for 5 clocks, and require high_cnt to stop at 3 and cnt_sat=1 from the third count onward.
REQ-033 A bench SHALL assert rst for 1 cycle after 4 counting cycles, and require all registered outputs to return to their reset values while out still tracks its inputs.
REQ-034 A bench SHALL pulse in1 between clock edges, and require out to follow the pulse while out_q, high_cnt and toggle_cnt stay unchanged.
